// File: rtl/serial_eq_ctrl.sv
// Bit-serial word comparator sequencer for a shared 1-bit eq cell.
// Streams operand bits LSB first and records the first mismatch.
module serial_eq_ctrl #(
  parameter int WIDTH = 8,
  parameter bit EARLY_EXIT = 1'b1,
  localparam int IW = $clog2(WIDTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic          bit_x,
  output logic          bit_y,
  input  logic          eq_s,
  output logic          busy,
  output logic          done,
  output logic          match,
  output logic [IW-1:0] mismatch_idx
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             match_q, match_d;
  logic [IW-1:0]    midx_q, midx_d;

  logic last;
  logic stop;

  assign last = (idx_q == IW'(WIDTH - 1));
  assign stop = (!eq_s && EARLY_EXIT) || last;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state: scan until mismatch (early exit) or last bit
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start) state_d = CMP;
      CMP:  if (stop)  state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next-state: capture, shift, first-mismatch record
  always_comb begin
    sa_d    = sa_q;
    sb_d    = sb_q;
    idx_d   = idx_q;
    match_d = match_q;
    midx_d  = midx_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          sa_d    = a;
          sb_d    = b;
          idx_d   = '0;
          match_d = 1'b1;
          midx_d  = '0;
        end
      end
      CMP: begin
        if (!eq_s && match_q) begin
          match_d = 1'b0;
          midx_d  = idx_q;
        end
        if (!stop) begin
          sa_d  = sa_q >> 1;
          sb_d  = sb_q >> 1;
          idx_d = idx_q + IW'(1);
        end
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa_q    <= '0;
      sb_q    <= '0;
      idx_q   <= '0;
      match_q <= 1'b0;
      midx_q  <= '0;
    end else begin
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      idx_q   <= idx_d;
      match_q <= match_d;
      midx_q  <= midx_d;
    end
  end

  // Outputs: cell bits only driven while scanning
  always_comb begin
    bit_x        = 1'b0;
    bit_y        = 1'b0;
    busy         = (state_q != IDLE);
    done         = (state_q == DONE);
    match        = match_q;
    mismatch_idx = midx_q;
    if (state_q == CMP) begin
      bit_x = sa_q[0];
      bit_y = sb_q[0];
    end
  end

endmodule

// File: tb/tb_serial_eq_ctrl.sv
// Bench for serial_eq_ctrl: four instances (W8/W2 x early-exit on/off)
// each driving its own eq cell, checked against a word-level model.
module tb_serial_eq_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [3:0]      st;
  logic [3:0][7:0] av;
  logic [3:0][7:0] bv;
  wire  [3:0]      bx, by, es, bz, dn, mt;
  wire  [3:0][2:0] mi;

  assign es = ~(bx ^ by);
  assign mi[2][2:1] = 2'b00;
  assign mi[3][2:1] = 2'b00;

  int n_tests = 0;
  int n_fail  = 0;

  serial_eq_ctrl #(.WIDTH(8), .EARLY_EXIT(1'b1)) u0 (
    .clk(clk), .rst_n(rst_n), .start(st[0]),
    .a(av[0]), .b(bv[0]),
    .bit_x(bx[0]), .bit_y(by[0]), .eq_s(es[0]),
    .busy(bz[0]), .done(dn[0]), .match(mt[0]),
    .mismatch_idx(mi[0])
  );

  serial_eq_ctrl #(.WIDTH(8), .EARLY_EXIT(1'b0)) u1 (
    .clk(clk), .rst_n(rst_n), .start(st[1]),
    .a(av[1]), .b(bv[1]),
    .bit_x(bx[1]), .bit_y(by[1]), .eq_s(es[1]),
    .busy(bz[1]), .done(dn[1]), .match(mt[1]),
    .mismatch_idx(mi[1])
  );

  serial_eq_ctrl #(.WIDTH(2), .EARLY_EXIT(1'b1)) u2 (
    .clk(clk), .rst_n(rst_n), .start(st[2]),
    .a(av[2][1:0]), .b(bv[2][1:0]),
    .bit_x(bx[2]), .bit_y(by[2]), .eq_s(es[2]),
    .busy(bz[2]), .done(dn[2]), .match(mt[2]),
    .mismatch_idx(mi[2][0:0])
  );

  serial_eq_ctrl #(.WIDTH(2), .EARLY_EXIT(1'b0)) u3 (
    .clk(clk), .rst_n(rst_n), .start(st[3]),
    .a(av[3][1:0]), .b(bv[3][1:0]),
    .bit_x(bx[3]), .bit_y(by[3]), .eq_s(es[3]),
    .busy(bz[3]), .done(dn[3]), .match(mt[3]),
    .mismatch_idx(mi[3][0:0])
  );

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Word-level reference: equality, lowest differing bit, scan length
  function automatic void model(
    input  int a, input int b, input int w, input bit ee,
    output bit m, output int idx, output int len
  );
    int x;
    x = (a ^ b) & ((1 << w) - 1);
    m = (x == 0);
    idx = 0;
    if (!m)
      while (((x >> idx) & 1) == 0) idx++;
    len = (!m && ee) ? idx + 1 : w;
  endfunction

  task automatic run(
    input int d, input logic [7:0] a, input logic [7:0] b, input bit inj
  );
    int  w, len, eidx, n, sx, sy;
    bit  ee, em, seen;
    w  = (d < 2) ? 8 : 2;
    ee = (d == 0) || (d == 2);
    model(int'(a), int'(b), w, ee, em, eidx, len);
    @(negedge clk);
    check("idle_busy", int'(bz[d]), 0);
    av[d] = a;
    bv[d] = b;
    st[d] = 1'b1;
    @(posedge clk);
    #1;
    st[d] = 1'b0;
    n = 0; sx = 0; sy = 0; seen = 1'b0;
    while (n < 20) begin
      if (dn[d]) begin
        seen = 1'b1;
        break;
      end
      sx |= int'(bx[d]) << n;
      sy |= int'(by[d]) << n;
      n++;
      if (inj && n == 2) begin
        st[d] = 1'b1;
        av[d] = ~a;
        bv[d] = a ^ 8'h01;
      end else begin
        st[d] = 1'b0;
      end
      @(posedge clk);
      #1;
    end
    st[d] = 1'b0;
    check("done_seen", int'(seen), 1);
    check("latency", n, len);
    check("seq_x", sx, int'(a) & ((1 << len) - 1));
    check("seq_y", sy, int'(b) & ((1 << len) - 1));
    check("match", int'(mt[d]), int'(em));
    check("midx", int'(mi[d]), eidx);
    check("busy_done", int'(bz[d]), 1);
    @(posedge clk);
    #1;
    check("done_pulse", int'(dn[d]), 0);
    check("busy_idle", int'(bz[d]), 0);
    check("match_hold", int'(mt[d]), int'(em));
    check("midx_hold", int'(mi[d]), eidx);
  endtask

  initial begin
    logic [7:0] ra, rb;
    int         rd, rk;
    st = '0;
    av = '0;
    bv = '0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      check("rst_busy", int'(bz[i]), 0);
      check("rst_done", int'(dn[i]), 0);
      check("rst_match", int'(mt[i]), 0);
      check("rst_midx", int'(mi[i]), 0);
      check("rst_bits", int'({bx[i], by[i]}), 0);
    end
    rst_n = 1'b1;

    run(0, 8'hA5, 8'hA5, 1'b0);
    run(0, 8'h10, 8'h00, 1'b0);
    run(1, 8'h81, 8'h00, 1'b0);
    run(1, 8'h5A, 8'h5A, 1'b1);
    run(0, 8'h3C, 8'h3C, 1'b1);

    // Reset mid-scan at idx=3 on the full-scan instance
    @(negedge clk);
    av[1] = 8'hFF;
    bv[1] = 8'hFF;
    st[1] = 1'b1;
    @(posedge clk);
    #1;
    st[1] = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_busy", int'(bz[1]), 0);
    check("arst_done", int'(dn[1]), 0);
    check("arst_match", int'(mt[1]), 0);
    check("arst_midx", int'(mi[1]), 0);
    check("arst_bits", int'({bx[1], by[1]}), 0);
    repeat (3) begin
      @(posedge clk);
      #1;
      check("arst_nodone", int'(dn), 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run(1, 8'h0F, 8'h0E, 1'b0);

    for (int i = 0; i < 60; i++) begin
      rd = $urandom_range(0, 3);
      ra = 8'($urandom);
      rk = $urandom_range(0, 2);
      if (rk == 0)      rb = ra;
      else if (rk == 1) rb = ra ^ (8'h01 << $urandom_range(0, 7));
      else              rb = 8'($urandom);
      run(rd, ra, rb, 1'b0);
    end

    for (int d = 2; d < 4; d++)
      for (int x = 0; x < 4; x++)
        for (int y = 0; y < 4; y++)
          run(d, 8'(x), 8'(y), 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
